// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR0  = 3'd1,
      HDR1  = 3'd2,
      DATA  = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } loader_state_e;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

   // A load session is in progress while the header or payload is being handled.
   function automatic logic is_busy(input loader_state_e s);
      return s inside {HDR0, HDR1, DATA, WRITE};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: loader side (accepts bytes, drives the write port).
// slave:  host/memory side (drives bytes, observes the write port).
interface imem_loader_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_waddr;
   logic [DATA_WIDTH-1:0] imem_wdata;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian stream bytes into a 32-bit word (first byte -> [7:0]).
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        load_i,
   input  logic [7:0]  byte_i,
   output logic        word_full_o,
   output logic [31:0] word_o
);

   logic [1:0]  idx_q;
   logic [31:0] pack_q, pack_d;

   // Current byte merged into its lane; the FSM samples this on the last byte.
   always_comb begin
      pack_d = pack_q;
      pack_d[{idx_q, 3'b000} +: 8] = byte_i;
   end

   assign word_o      = pack_d;
   assign word_full_o = (idx_q == 2'(BYTES_PER_WORD - 1));

   // Byte index wraps naturally after the fourth byte of a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         pack_q <= '0;
      end else if (clear_i) begin
         idx_q  <= '0;
         pack_q <= '0;
      end else if (load_i) begin
         idx_q  <= idx_q + 2'd1;
         pack_q <= pack_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length header, packs payload bytes into words,
// writes them to instruction memory and holds the core in reset until done.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned PROGRAM_LENGTH = 10,
   parameter bit          BOOT_RUN       = 1'b1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start_i,
   imem_loader_if.master                         bus,
   output logic                                  cpu_rst_n_o,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  err_o,
   output logic [$clog2(PROGRAM_LENGTH+1)-1:0]   words_loaded_o
);

   localparam int unsigned CNT_W = $clog2(PROGRAM_LENGTH + 1);

   loader_state_e         state_q, state_d;
   logic [7:0]            hdr_lo_q, hdr_lo_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [CNT_W-1:0]      widx_q, widx_d;
   logic [CNT_W-1:0]      loaded_q, loaded_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  cpu_rst_n_q, cpu_rst_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic [15:0]           hdr_n;
   logic                  pk_clear, pk_load, pk_full;
   logic [31:0]           pk_word;

   assign bus.byte_ready = state_q inside {HDR0, HDR1, DATA};
   assign accept         = bus.byte_valid & bus.byte_ready;
   assign hdr_n          = {bus.byte_data, hdr_lo_q};

   imem_word_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (pk_clear),
      .load_i     (pk_load),
      .byte_i     (bus.byte_data),
      .word_full_o(pk_full),
      .word_o     (pk_word)
   );

   // Next-state and next-output decode; write-port and status outputs are
   // registered on entry to the state that owns them.
   always_comb begin
      state_d     = state_q;
      hdr_lo_d    = hdr_lo_q;
      len_d       = len_q;
      widx_d      = widx_q;
      loaded_d    = loaded_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      cpu_rst_n_d = cpu_rst_n_q;
      done_d      = done_q;
      err_d       = err_q;
      pk_clear    = 1'b0;
      pk_load     = 1'b0;
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start_i) begin
               state_d     = HDR0;
               done_d      = 1'b0;
               err_d       = 1'b0;
               loaded_d    = '0;
               widx_d      = '0;
               pk_clear    = 1'b1;
               cpu_rst_n_d = 1'b0;
            end
         end
         HDR0: begin
            if (accept) begin
               hdr_lo_d = bus.byte_data;
               state_d  = HDR1;
            end
         end
         HDR1: begin
            if (accept) begin
               if (hdr_n == 16'd0) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  cpu_rst_n_d = 1'b1;
               end else if (hdr_n > 16'(PROGRAM_LENGTH)) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  len_d   = hdr_n[CNT_W-1:0];
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               pk_load = 1'b1;
               if (pk_full) begin
                  state_d  = WRITE;
                  we_d     = 1'b1;
                  waddr_d  = ADDR_WIDTH'({widx_q, 2'b00});
                  wdata_d  = DATA_WIDTH'(pk_word);
                  widx_d   = widx_q + 1'b1;
                  loaded_d = loaded_q + 1'b1;
               end
            end
         end
         WRITE: begin
            if (widx_q == len_q) begin
               state_d     = DONE;
               done_d      = 1'b1;
               cpu_rst_n_d = 1'b1;
            end else begin
               state_d = DATA;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = is_busy(state_d);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hdr_lo_q    <= '0;
         len_q       <= '0;
         widx_q      <= '0;
         loaded_q    <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         cpu_rst_n_q <= BOOT_RUN;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_lo_q    <= hdr_lo_d;
         len_q       <= len_d;
         widx_q      <= widx_d;
         loaded_q    <= loaded_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.imem_we     = we_q;
   assign bus.imem_waddr  = waddr_q;
   assign bus.imem_wdata  = wdata_q;
   assign cpu_rst_n_o     = cpu_rst_n_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign err_o           = err_q;
   assign words_loaded_o  = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, packing, write timing,
// error rejection, stalls, mid-session reset and reload from DONE.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       start1;
   logic       cpu0, busy0, done0, err0;
   logic       cpu1, busy1, done1, err1;
   logic [3:0] wl0, wl1;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] wlog_addr [64];
   logic [31:0] wlog_data [64];
   int unsigned wcount = 0;
   int unsigned base;

   imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   imem_loader #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROGRAM_LENGTH(10), .BOOT_RUN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bus0.master),
      .cpu_rst_n_o(cpu0), .busy_o(busy0), .done_o(done0), .err_o(err0),
      .words_loaded_o(wl0)
   );

   imem_loader #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROGRAM_LENGTH(10), .BOOT_RUN(1'b0)
   ) dut_hold (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .bus(bus1.master),
      .cpu_rst_n_o(cpu1), .busy_o(busy1), .done_o(done1), .err_o(err1),
      .words_loaded_o(wl1)
   );

   assign start1          = 1'b0;
   assign bus1.byte_valid = 1'b0;
   assign bus1.byte_data  = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-port monitor for the main instance.
   always @(posedge clk) begin
      if (bus0.imem_we) begin
         if (wcount < 64) begin
            wlog_addr[wcount] <= bus0.imem_waddr;
            wlog_data[wcount] <= bus0.imem_wdata;
         end
         wcount <= wcount + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Idle cycles between bytes, optionally pulsing start_i (must be ignored while busy).
   task automatic gap(input int unsigned cycles, input bit with_start);
      for (int unsigned i = 0; i < cycles; i++) begin
         start = with_start;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   // Entered and left on a falling edge; holds the byte until accepted.
   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int unsigned n = 0;
      if (rnd) gap($urandom_range(0, 3), 1'b1);
      bus0.byte_valid = 1'b1;
      bus0.byte_data  = b;
      while (!bus0.byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("ready_timeout", 64'(bus0.byte_ready), 64'd1);
      @(negedge clk);
      bus0.byte_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [15:0] n, input bit rnd);
      for (int unsigned i = 0; i < HDR_BYTES; i++) send_byte(n[8*i +: 8], rnd);
   endtask

   task automatic send_word(input logic [31:0] w, input bit rnd);
      for (int unsigned i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
   endtask

   task automatic wait_done();
      int unsigned n = 0;
      while (!done0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("done_wait", 64'(done0), 64'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_cpu"},   64'(cpu0), 64'd1);
      check({tag, "_busy"},  64'(busy0), 64'd0);
      check({tag, "_done"},  64'(done0), 64'd0);
      check({tag, "_err"},   64'(err0), 64'd0);
      check({tag, "_we"},    64'(bus0.imem_we), 64'd0);
      check({tag, "_waddr"}, 64'(bus0.imem_waddr), 64'd0);
      check({tag, "_wdata"}, 64'(bus0.imem_wdata), 64'd0);
      check({tag, "_wl"},    64'(wl0), 64'd0);
      check({tag, "_ready"}, 64'(bus0.byte_ready), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      start           = 1'b0;
      bus0.byte_valid = 1'b0;
      bus0.byte_data  = 8'h00;

      // 1: reset values for both BOOT_RUN settings
      @(negedge clk);
      check_reset_state("rst");
      check("rst_hold_cpu", 64'(cpu1), 64'd0);
      check("rst_hold_busy", 64'(busy1), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 2: two-word image at full rate with exact write timing
      base = wcount;
      pulse_start();
      check("t2_busy", 64'(busy0), 64'd1);
      check("t2_cpu_held", 64'(cpu0), 64'd0);
      send_hdr(16'd2, 1'b0);
      send_word(32'h00500013, 1'b0);
      check("t2_we0", 64'(bus0.imem_we), 64'd1);
      check("t2_addr0", 64'(bus0.imem_waddr), 64'h0);
      check("t2_data0", 64'(bus0.imem_wdata), 64'h00500013);
      send_word(32'h00A00093, 1'b0);
      check("t2_we1", 64'(bus0.imem_we), 64'd1);
      check("t2_addr1", 64'(bus0.imem_waddr), 64'h4);
      check("t2_data1", 64'(bus0.imem_wdata), 64'h00A00093);
      check("t2_cpu_before", 64'(cpu0), 64'd0);
      @(negedge clk);
      check("t2_done", 64'(done0), 64'd1);
      check("t2_cpu", 64'(cpu0), 64'd1);
      check("t2_wl", 64'(wl0), 64'd2);
      check("t2_we_pulse", 64'(bus0.imem_we), 64'd0);
      check("t2_busy_end", 64'(busy0), 64'd0);
      check("t2_nwrites", 64'(wcount - base), 64'd2);

      // 3: oversize header is rejected without consuming payload
      base = wcount;
      pulse_start();
      send_hdr(16'd11, 1'b0);
      check("t3_err", 64'(err0), 64'd1);
      check("t3_done", 64'(done0), 64'd0);
      check("t3_cpu", 64'(cpu0), 64'd0);
      check("t3_ready", 64'(bus0.byte_ready), 64'd0);
      bus0.byte_valid = 1'b1;
      bus0.byte_data  = 8'h13;
      repeat (3) @(negedge clk);
      bus0.byte_valid = 1'b0;
      check("t3_err_hold", 64'(err0), 64'd1);
      check("t3_nwrites", 64'(wcount - base), 64'd0);

      // 4: same image with random stalls and start pulses while busy
      base = wcount;
      pulse_start();
      check("t4_err_clr", 64'(err0), 64'd0);
      send_hdr(16'd2, 1'b1);
      send_word(32'h00500013, 1'b1);
      send_word(32'h00A00093, 1'b1);
      wait_done();
      check("t4_wl", 64'(wl0), 64'd2);
      check("t4_cpu", 64'(cpu0), 64'd1);
      check("t4_nwrites", 64'(wcount - base), 64'd2);
      check("t4_addr0", 64'(wlog_addr[base]), 64'h0);
      check("t4_data0", 64'(wlog_data[base]), 64'h00500013);
      check("t4_addr1", 64'(wlog_addr[base+1]), 64'h4);
      check("t4_data1", 64'(wlog_data[base+1]), 64'h00A00093);

      // 5: reset mid-word, then a one-word image
      base = wcount;
      pulse_start();
      send_hdr(16'd2, 1'b0);
      send_word(32'h00500013, 1'b0);
      send_byte(8'h93, 1'b0);
      send_byte(8'h00, 1'b0);
      check("t5_nwrites_pre", 64'(wcount - base), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_state("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base = wcount;
      pulse_start();
      send_hdr(16'd1, 1'b0);
      send_word(32'h00000073, 1'b0);
      check("t5_we", 64'(bus0.imem_we), 64'd1);
      check("t5_addr", 64'(bus0.imem_waddr), 64'h0);
      check("t5_data", 64'(bus0.imem_wdata), 64'h00000073);
      @(negedge clk);
      check("t5_done", 64'(done0), 64'd1);
      check("t5_wl", 64'(wl0), 64'd1);
      check("t5_nwrites", 64'(wcount - base), 64'd1);

      // 6: empty image, then reload a full-depth image from DONE
      base = wcount;
      pulse_start();
      send_hdr(16'd0, 1'b0);
      check("t6_done0", 64'(done0), 64'd1);
      check("t6_cpu0", 64'(cpu0), 64'd1);
      check("t6_busy0", 64'(busy0), 64'd0);
      check("t6_wl0", 64'(wl0), 64'd0);
      check("t6_nwrites0", 64'(wcount - base), 64'd0);
      pulse_start();
      check("t6_reload_cpu", 64'(cpu0), 64'd0);
      check("t6_reload_done", 64'(done0), 64'd0);
      send_hdr(16'd10, 1'b0);
      for (int unsigned i = 0; i < 10; i++) send_word(32'hA5000000 + i * 32'h01010101, 1'b0);
      @(negedge clk);
      check("t6_done", 64'(done0), 64'd1);
      check("t6_err", 64'(err0), 64'd0);
      check("t6_wl", 64'(wl0), 64'd10);
      check("t6_nwrites", 64'(wcount - base), 64'd10);
      for (int unsigned i = 0; i < 10; i++) begin
         check($sformatf("t6_addr%0d", i), 64'(wlog_addr[base+i]), 64'(4 * i));
         check($sformatf("t6_data%0d", i), 64'(wlog_data[base+i]), 64'(32'hA5000000 + i * 32'h01010101));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
